switch_debouncer: RTL and testbench

//   Conditions the raw board switches before they reach the S-Machine core's switch0/switch1 inputs.
//   Per channel: 2-flop synchronizer, then a consecutive-sample debounce counter.

---
 rtl/switch_debouncer.sv | 102 ++++++++++
 tb/tb_switch_debouncer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions raw board switches for the S-Machine core.
// Each channel passes through a 2-flop synchronizer and then a
// consecutive-sample debounce FSM. Outputs are a registered clean level plus
// registered one-cycle rise/fall strobes. Channels are fully independent.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   STABLE  | synchronized input matches sw_stable (or enable low), cnt==0
//   PENDING | synchronized input differs from sw_stable, counting samples
module switch_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Two-flop synchronizer for the asynchronous pin levels; runs regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             rise;
    logic             fall;

    // Debounce FSM: accept a new level only after DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= STABLE;
        cnt    <= '0;
        stable <= 1'b0;
        rise   <= 1'b0;
        fall   <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        case (state)
          STABLE: begin
            if (enable && (s2[i] != stable)) begin
              cnt   <= CNT_ONE;
              state <= PENDING;
            end
          end
          PENDING: begin
            if (!enable) begin
              cnt   <= '0;
              state <= STABLE;
            end else if (s2[i] == stable) begin
              // bounced back before the count completed
              cnt   <= '0;
              state <= STABLE;
            end else if (cnt == CNT_LAST) begin
              stable <= s2[i];
              rise   <= s2[i];
              fall   <= ~s2[i];
              cnt    <= '0;
              state  <= STABLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= STABLE;
          end
        endcase
      end
    end

    assign sw_stable[i] = stable;
    assign sw_rise[i]   = rise;
    assign sw_fall[i]   = fall;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed stimulus with a strobe scoreboard.
// Stimulus pushes the expected strobe event (cycle, rise, fall, level) into a
// queue; the monitor pops and compares whenever any strobe is high.
module tb_switch_debouncer;

  localparam int W = 2;
  localparam int D = 4;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic         enable = 1'b1;
  logic [W-1:0] sw_raw = 2'b11;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           cyc;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] stable;
    string        name;
  } exp_t;

  exp_t q[$];

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin : monitor
    exp_t e;
    if ((sw_rise | sw_fall) != '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: cycle %0d rise %b fall %b stable %b, none expected",
                 cyc, sw_rise, sw_fall, sw_stable);
      end else begin
        e = q.pop_front();
        check({e.name, "_cycle"},  cyc,       e.cyc);
        check({e.name, "_rise"},   sw_rise,   e.rise);
        check({e.name, "_fall"},   sw_fall,   e.fall);
        check({e.name, "_stable"}, sw_stable, e.stable);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input string name, input int dcyc,
                           input logic [W-1:0] r, input logic [W-1:0] f,
                           input logic [W-1:0] s);
    exp_t e;
    e.cyc    = cyc + dcyc;
    e.rise   = r;
    e.fall   = f;
    e.stable = s;
    e.name   = name;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: event expected at cycle %0d never seen (now %0d)",
               q[0].name, q[0].cyc, cyc);
      q.delete();
    end
  endtask

  initial begin
    tick(3);
    // 1. reset state
    check("reset_stable", sw_stable, 2'b00);
    check("reset_rise",   sw_rise,   2'b00);
    check("reset_fall",   sw_fall,   2'b00);
    reset = 1'b0;
    expect_ev("t1_rise", 6, 2'b11, 2'b00, 2'b11);
    drain();
    tick(2);

    // 2. clean release then clean press on channel 0
    sw_raw = 2'b10;
    expect_ev("t2_fall", 6, 2'b00, 2'b01, 2'b10);
    drain();
    tick(2);
    sw_raw = 2'b11;
    expect_ev("t2_rise", 6, 2'b01, 2'b00, 2'b11);
    drain();
    tick(2);

    // 3. bounce on channel 0
    sw_raw = 2'b10;
    expect_ev("t3_fall", 6, 2'b00, 2'b01, 2'b10);
    drain();
    tick(2);
    sw_raw = 2'b11; tick(1);
    sw_raw = 2'b10; tick(1);
    sw_raw = 2'b11; tick(1);
    sw_raw = 2'b10; tick(1);
    sw_raw = 2'b11;
    expect_ev("t3_rise", 6, 2'b01, 2'b00, 2'b11);
    drain();
    tick(2);

    // 4. 3-cycle glitch on channel 1 is rejected
    sw_raw = 2'b01;
    tick(3);
    sw_raw = 2'b11;
    tick(8);
    check("t4_stable", sw_stable, 2'b11);

    // 5. enable gating
    sw_raw = 2'b00;
    expect_ev("t5_fall", 6, 2'b00, 2'b11, 2'b00);
    drain();
    tick(2);
    enable = 1'b0;
    sw_raw = 2'b01;
    tick(20);
    check("t5_gated_stable", sw_stable, 2'b00);
    enable = 1'b1;
    expect_ev("t5_rise", 4, 2'b01, 2'b00, 2'b01);
    drain();
    tick(2);

    // 6. reset two cycles into a pending change
    sw_raw = 2'b11;
    tick(4);
    reset = 1'b1;
    #1;
    check("t6_reset_stable", sw_stable, 2'b00);
    check("t6_reset_rise",   sw_rise,   2'b00);
    check("t6_reset_fall",   sw_fall,   2'b00);
    tick(2);
    reset = 1'b0;
    expect_ev("t6_rise", 6, 2'b11, 2'b00, 2'b11);
    drain();
    tick(5);
    check("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
